// File: rtl/stage_two_pkg.sv
// rtl/stage_two_pkg.sv - shared types for the execute stage and its iterative divider
package stage_two_pkg;

   localparam int DIV_W = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLL = 3'd4,
      ALU_SRL = 3'd5,
      ALU_MUL = 3'd6,
      ALU_DIV = 3'd7
   } control_e;

   typedef struct packed {
      logic [DIV_W-1:0] a;
      logic [DIV_W-1:0] b;
   } in_t;

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [1:0] size;
   } memc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Two's-complement add overflow from the sign bits of both addends and the sum
   function automatic logic add_ovf(input logic s_a, input logic s_b, input logic s_sum);
      return (s_a == s_b) && (s_sum != s_a);
   endfunction

endpackage

// File: rtl/stage_two_if.sv
// rtl/stage_two_if.sv - stage-one to stage-two pipeline bundle
interface stage_two_if;
   import stage_two_pkg::*;

   memc_t       memc;
   logic        reg_wr;
   in_t         alu;
   control_e    alu_ctrl;
   logic        haz1;
   logic        haz2;
   logic        haz8;
   logic        R0_en;
   logic [15:0] instr;
   logic [15:0] R1_data;

   modport master (
      output memc, reg_wr, alu, alu_ctrl, haz1, haz2, haz8, R0_en, instr, R1_data
   );

   modport slave (
      input memc, reg_wr, alu, alu_ctrl, haz1, haz2, haz8, R0_en, instr, R1_data
   );

endinterface

// File: rtl/stage_two_div_iter.sv
// rtl/stage_two_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
module stage_two_div_iter
   import stage_two_pkg::*;
#(
   parameter int DIV_CYCLES = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_halt_sys,
   input  logic             i_start,
   input  logic [DIV_W-1:0] i_a,
   input  logic [DIV_W-1:0] i_b,
   output logic             o_idle,
   output logic             o_busy,
   output logic             o_done,
   output logic [DIV_W-1:0] o_quot,
   output logic [DIV_W-1:0] o_rem
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   div_state_e       r_state;
   div_state_e       w_next;
   logic [CNT_W-1:0] r_count;
   logic [DIV_W-1:0] r_quo;
   logic [DIV_W-1:0] r_rem;
   logic [DIV_W-1:0] r_div;
   logic             r_busy;
   logic [DIV_W:0]   w_trial;
   logic [DIV_W:0]   w_diff;
   logic             w_last;

   // Dividend bits shift out of r_quo into the partial remainder as quotient bits shift in
   assign w_trial = {r_rem, r_quo[DIV_W-1]};
   assign w_diff  = w_trial - {1'b0, r_div};
   assign w_last  = (r_count == CNT_W'(DIV_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else if (!i_halt_sys) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_busy  <= 1'b0;
      end else if (!i_halt_sys) begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_quo   <= i_a;
                  r_rem   <= '0;
                  r_div   <= i_b;
                  r_count <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               r_count <= r_count + CNT_W'(1);
               r_quo   <= {r_quo[DIV_W-2:0], ~w_diff[DIV_W]};
               r_rem   <= w_diff[DIV_W] ? w_trial[DIV_W-1:0] : w_diff[DIV_W-1:0];
               if (w_last) r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_idle = (r_state == IDLE);
   assign o_busy = r_busy;
   assign o_done = (r_state == DONE);
   assign o_quot = r_quo;
   assign o_rem  = r_rem;

endmodule

// File: rtl/stage_two.sv
// rtl/stage_two.sv - execute stage: ALU, iterative divider and stage-two pipeline flop
module stage_two
   import stage_two_pkg::*;
#(
   parameter int DIV_CYCLES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_halt_sys,
   stage_two_if.slave        i_s1,
   output logic [31:0]       o_s2_alu,
   output logic              o_div0,
   output logic              o_overflow,
   output logic              o_div_busy,
   output memc_t             o_memc,
   output logic              o_reg_wr,
   output logic              o_R0_en,
   output logic [15:0]       o_instr,
   output logic [15:0]       o_R1_data,
   output logic [31:0]       o_result
);

   logic [15:0] w_a;
   logic [15:0] w_b;
   logic [15:0] w_r1;
   logic [15:0] w_b_add;
   logic [15:0] w_sum;
   logic [31:0] w_prod;
   logic        w_is_sub;
   logic        w_div_start;
   logic        w_div_idle;
   logic        w_div_done;
   logic        w_bubble;
   logic [15:0] w_quot;
   logic [15:0] w_rem;

   assign w_a  = i_s1.haz1 ? o_result[15:0] : i_s1.alu.a;
   assign w_b  = i_s1.haz2 ? o_result[15:0] : i_s1.alu.b;
   assign w_r1 = i_s1.haz8 ? o_result[15:0] : i_s1.R1_data;

   // SUB is a + ~b + 1 so the same adder and overflow rule serve both
   assign w_is_sub = (i_s1.alu_ctrl == ALU_SUB);
   assign w_b_add  = w_is_sub ? ~w_b : w_b;
   assign w_sum    = w_a + w_b_add + {15'd0, w_is_sub};
   assign w_prod   = {{16{w_a[15]}}, w_a} * {{16{w_b[15]}}, w_b};

   assign w_div_start = (i_s1.alu_ctrl == ALU_DIV) && (w_b != 16'd0)
                        && !i_halt_sys && w_div_idle;

   stage_two_div_iter #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_halt_sys (i_halt_sys),
      .i_start    (w_div_start),
      .i_a        (w_a),
      .i_b        (w_b),
      .o_idle     (w_div_idle),
      .o_busy     (o_div_busy),
      .o_done     (w_div_done),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   always_comb begin
      o_s2_alu   = '0;
      o_overflow = 1'b0;
      o_div0     = 1'b0;
      if (w_div_done) begin
         o_s2_alu = {w_rem, w_quot};
      end else begin
         case (i_s1.alu_ctrl)
            ALU_ADD, ALU_SUB: begin
               o_s2_alu   = {16'd0, w_sum};
               o_overflow = add_ovf(w_a[15], w_b_add[15], w_sum[15]);
            end
            ALU_AND: o_s2_alu = {16'd0, w_a & w_b};
            ALU_OR:  o_s2_alu = {16'd0, w_a | w_b};
            ALU_SLL: o_s2_alu = {16'd0, w_a << w_b[3:0]};
            ALU_SRL: o_s2_alu = {16'd0, w_a >> w_b[3:0]};
            ALU_MUL: o_s2_alu = w_prod;
            ALU_DIV: o_div0   = (w_b == 16'd0);
            default: o_s2_alu = '0;
         endcase
      end
   end

   // The DIV itself stays parked in stage one until DONE, so its start cycle is a bubble too
   assign w_bubble = o_div_busy || w_div_start;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_memc    <= '0;
         o_reg_wr  <= 1'b0;
         o_R0_en   <= 1'b0;
         o_instr   <= '0;
         o_R1_data <= '0;
         o_result  <= '0;
      end else if (!i_halt_sys) begin
         if (w_bubble) begin
            o_memc   <= '0;
            o_reg_wr <= 1'b0;
            o_R0_en  <= 1'b0;
         end else begin
            o_memc    <= i_s1.memc;
            o_reg_wr  <= i_s1.reg_wr;
            o_R0_en   <= i_s1.R0_en;
            o_instr   <= i_s1.instr;
            o_R1_data <= w_r1;
            o_result  <= o_s2_alu;
         end
      end
   end

endmodule
